// File: rtl/aq_axi_freq_poller_if.sv
// AXI4-Lite bus between the frequency poller (master) and the frequency slave.
interface aq_axi_freq_poller_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic [ADDR_W-1:0] M_AXI_AWADDR;
   logic [3:0]        M_AXI_AWCACHE;
   logic [2:0]        M_AXI_AWPROT;
   logic              M_AXI_AWVALID;
   logic              M_AXI_AWREADY;

   logic [DATA_W-1:0] M_AXI_WDATA;
   logic [3:0]        M_AXI_WSTRB;
   logic              M_AXI_WVALID;
   logic              M_AXI_WREADY;

   logic              M_AXI_BVALID;
   logic              M_AXI_BREADY;
   logic [1:0]        M_AXI_BRESP;

   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [3:0]        M_AXI_ARCACHE;
   logic [2:0]        M_AXI_ARPROT;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;

   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BVALID, M_AXI_BRESP,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BVALID, M_AXI_BRESP,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );
endinterface

// File: rtl/aq_axi_freq_poller.sv
// AXI4-Lite master: set/clear the frequency slave, wait out the gate, read FREQ.
// Define AQ_FREQ_POLLER_AUTO_EN to restart automatically after each successful read.
module aq_axi_freq_poller #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] WAIT_CYCLES = 32'd100000016,
   parameter logic [15:0] TIMEOUT     = 16'd1024
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        START,
   output logic        BUSY,
   output logic [31:0] FREQ_VALUE,
   output logic        FREQ_VALID,
   output logic        ERROR,
   aq_axi_freq_poller_if.master m_axi
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TMO_W  = 16;

   typedef enum logic [2:0] {
      IDLE, WR_SET, WR_SET_B, WR_CLR, WR_CLR_B, WAIT, RD_A, RD_R
   } state_t;

   state_t              state_q, state_d;
   logic                aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
   logic                b_ready_q, b_ready_d, ar_valid_q, ar_valid_d;
   logic                r_ready_q, r_ready_d;
   logic [DATA_W-1:0]   awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
   logic [DATA_W-1:0]   freq_value_q, freq_value_d, wait_q, wait_d;
   logic                freq_valid_q, freq_valid_d, error_q, error_d, busy_q, busy_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                go, in_hs;
`ifdef AQ_FREQ_POLLER_AUTO_EN
   logic                auto_q, auto_d;
`endif

   // Write response code carries no information the sequence acts on.
   logic unused_bresp;
   assign unused_bresp = ^m_axi.M_AXI_BRESP;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= IDLE;
         aw_valid_q   <= 1'b0;
         w_valid_q    <= 1'b0;
         b_ready_q    <= 1'b0;
         ar_valid_q   <= 1'b0;
         r_ready_q    <= 1'b0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         araddr_q     <= '0;
         freq_value_q <= '0;
         wait_q       <= '0;
         freq_valid_q <= 1'b0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
         tmo_q        <= '0;
`ifdef AQ_FREQ_POLLER_AUTO_EN
         auto_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         aw_valid_q   <= aw_valid_d;
         w_valid_q    <= w_valid_d;
         b_ready_q    <= b_ready_d;
         ar_valid_q   <= ar_valid_d;
         r_ready_q    <= r_ready_d;
         awaddr_q     <= awaddr_d;
         wdata_q      <= wdata_d;
         araddr_q     <= araddr_d;
         freq_value_q <= freq_value_d;
         wait_q       <= wait_d;
         freq_valid_q <= freq_valid_d;
         error_q      <= error_d;
         busy_q       <= busy_d;
         tmo_q        <= tmo_d;
`ifdef AQ_FREQ_POLLER_AUTO_EN
         auto_q       <= auto_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      aw_valid_d   = aw_valid_q;
      w_valid_d    = w_valid_q;
      b_ready_d    = b_ready_q;
      ar_valid_d   = ar_valid_q;
      r_ready_d    = r_ready_q;
      awaddr_d     = awaddr_q;
      wdata_d      = wdata_q;
      araddr_d     = araddr_q;
      freq_value_d = freq_value_q;
      wait_d       = wait_q;
      freq_valid_d = 1'b0;
      error_d      = error_q;
      go           = START;
`ifdef AQ_FREQ_POLLER_AUTO_EN
      auto_d       = auto_q;
      go           = START | auto_q;
`endif

      case (state_q)
         IDLE: begin
            if (go) begin
               error_d    = 1'b0;
               awaddr_d   = BASE_ADDR;
               wdata_d    = 32'h8000_0000;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               state_d    = WR_SET;
`ifdef AQ_FREQ_POLLER_AUTO_EN
               auto_d     = 1'b0;
`endif
            end
         end
         WR_SET, WR_CLR: begin
            // AW and W complete independently; move on once both are done.
            aw_valid_d = aw_valid_q & ~m_axi.M_AXI_AWREADY;
            w_valid_d  = w_valid_q & ~m_axi.M_AXI_WREADY;
            if (!aw_valid_d && !w_valid_d) begin
               b_ready_d = 1'b1;
               state_d   = (state_q == WR_SET) ? WR_SET_B : WR_CLR_B;
            end
         end
         WR_SET_B: begin
            if (m_axi.M_AXI_BVALID) begin
               b_ready_d  = 1'b0;
               wdata_d    = 32'h0;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               state_d    = WR_CLR;
            end
         end
         WR_CLR_B: begin
            if (m_axi.M_AXI_BVALID) begin
               b_ready_d = 1'b0;
               // A zero wait issues the read on the cycle right after the B handshake.
               if (WAIT_CYCLES == 32'd0) begin
                  ar_valid_d = 1'b1;
                  araddr_d   = BASE_ADDR + 32'd4;
                  state_d    = RD_A;
               end else begin
                  wait_d  = WAIT_CYCLES;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            wait_d = wait_q - 32'd1;
            if (wait_d == 32'd0) begin
               ar_valid_d = 1'b1;
               araddr_d   = BASE_ADDR + 32'd4;
               state_d    = RD_A;
            end
         end
         RD_A: begin
            if (m_axi.M_AXI_ARREADY) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_R;
            end
         end
         RD_R: begin
            if (m_axi.M_AXI_RVALID) begin
               r_ready_d = 1'b0;
               state_d   = IDLE;
               if (m_axi.M_AXI_RRESP == 2'b00) begin
                  freq_value_d = m_axi.M_AXI_RDATA;
                  freq_valid_d = 1'b1;
`ifdef AQ_FREQ_POLLER_AUTO_EN
                  auto_d       = 1'b1;
`endif
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort a handshake state that has made no transition for TIMEOUT cycles.
      in_hs = (state_q != IDLE) && (state_q != WAIT);
      if (in_hs && (state_d == state_q) && (tmo_q == TIMEOUT - 16'd1)) begin
         aw_valid_d = 1'b0;
         w_valid_d  = 1'b0;
         b_ready_d  = 1'b0;
         ar_valid_d = 1'b0;
         r_ready_d  = 1'b0;
         error_d    = 1'b1;
         state_d    = IDLE;
      end
      tmo_d  = (in_hs && (state_d == state_q)) ? tmo_q + 16'd1 : '0;
      busy_d = (state_d != IDLE);
   end

   assign BUSY       = busy_q;
   assign FREQ_VALUE = freq_value_q;
   assign FREQ_VALID = freq_valid_q;
   assign ERROR      = error_q;

   assign m_axi.M_AXI_AWADDR  = awaddr_q;
   assign m_axi.M_AXI_AWCACHE = 4'b0011;
   assign m_axi.M_AXI_AWPROT  = 3'b000;
   assign m_axi.M_AXI_AWVALID = aw_valid_q;
   assign m_axi.M_AXI_WDATA   = wdata_q;
   assign m_axi.M_AXI_WSTRB   = 4'hF;
   assign m_axi.M_AXI_WVALID  = w_valid_q;
   assign m_axi.M_AXI_BREADY  = b_ready_q;
   assign m_axi.M_AXI_ARADDR  = araddr_q;
   assign m_axi.M_AXI_ARCACHE = 4'b0011;
   assign m_axi.M_AXI_ARPROT  = 3'b000;
   assign m_axi.M_AXI_ARVALID = ar_valid_q;
   assign m_axi.M_AXI_RREADY  = r_ready_q;
endmodule

// File: tb/tb_aq_axi_freq_poller.sv
// Scoreboard bench for aq_axi_freq_poller against a behavioural AXI4-Lite slave.
module tb_aq_axi_freq_poller;
   localparam logic [31:0] BASE  = 32'h4000_1000;
   localparam logic [31:0] WAITC = 32'd20;
   localparam logic [15:0] TMO   = 16'd16;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        START = 1'b0;
   logic        BUSY, FREQ_VALID, ERROR;
   logic [31:0] FREQ_VALUE;

   aq_axi_freq_poller_if bus();

   aq_axi_freq_poller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC), .TIMEOUT(TMO)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .START(START), .BUSY(BUSY),
      .FREQ_VALUE(FREQ_VALUE), .FREQ_VALID(FREQ_VALID), .ERROR(ERROR), .m_axi(bus.master));

   always #5 ACLK = ~ACLK;

   typedef struct { logic [31:0] value; logic err; int nvalid; int nwr; logic rd; } exp_t;
   typedef struct { logic [31:0] d; logic [1:0] r; } rd_t;

   exp_t        exp_q[$];
   rd_t         rd_q[$];
   logic [31:0] aw_log[$], w_log[$], ar_log[$];
   int          total = 0, bad = 0;
   logic [31:0] model_val = 32'h0;
   int          exp_pulses = 0, seen_pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Slave: random or zero-wait readies, B/R held until accepted, read data from rd_q.
   logic rnd_mode = 1'b0, aw_stall = 1'b0, b_never = 1'b0;
   logic aw_got, w_got, ar_pend;
   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
   assign w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
   assign ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
   assign bus.M_AXI_BRESP = 2'b00;

   always @(posedge ACLK) begin
      if (ARESET) begin
         bus.M_AXI_AWREADY <= 1'b0;
         bus.M_AXI_WREADY  <= 1'b0;
         bus.M_AXI_ARREADY <= 1'b0;
         bus.M_AXI_BVALID  <= 1'b0;
         bus.M_AXI_RVALID  <= 1'b0;
         bus.M_AXI_RDATA   <= 32'h0;
         bus.M_AXI_RRESP   <= 2'b00;
         aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
         aw_log.delete(); w_log.delete(); ar_log.delete();
      end else begin
         bus.M_AXI_AWREADY <= !aw_stall && (!rnd_mode || ($urandom_range(3) != 0));
         bus.M_AXI_WREADY  <= !rnd_mode || ($urandom_range(3) != 0);
         bus.M_AXI_ARREADY <= !rnd_mode || ($urandom_range(3) != 0);
         if (aw_hs) aw_log.push_back(bus.M_AXI_AWADDR);
         if (w_hs)  w_log.push_back(bus.M_AXI_WDATA);
         if (ar_hs) ar_log.push_back(bus.M_AXI_ARADDR);
         aw_got  <= aw_got | aw_hs;
         w_got   <= w_got | w_hs;
         ar_pend <= ar_pend | ar_hs;
         if (bus.M_AXI_BVALID) begin
            if (bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
         end else if ((aw_got | aw_hs) && (w_got | w_hs) && !b_never &&
                      (!rnd_mode || ($urandom_range(3) != 0))) begin
            bus.M_AXI_BVALID <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (bus.M_AXI_RVALID) begin
            if (bus.M_AXI_RREADY) bus.M_AXI_RVALID <= 1'b0;
         end else if ((ar_pend | ar_hs) && (!rnd_mode || ($urandom_range(3) != 0))) begin
            bus.M_AXI_RVALID <= 1'b1;
            ar_pend <= 1'b0;
            if (rd_q.size() > 0) begin
               bus.M_AXI_RDATA <= rd_q[0].d;
               bus.M_AXI_RRESP <= rd_q[0].r;
               void'(rd_q.pop_front());
            end else begin
               bus.M_AXI_RDATA <= 32'h0;
               bus.M_AXI_RRESP <= 2'b00;
            end
         end
      end
   end

   // Monitor: each BUSY fall ends a measurement; compare it with the oldest expectation.
   initial begin
      exp_t e;
      logic busy_prev;
      int   vcnt;
      busy_prev = 1'b0;
      vcnt = 0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            busy_prev = 1'b0;
            vcnt = 0;
         end else begin
            if (FREQ_VALID) begin
               vcnt++;
               seen_pulses++;
            end
            if (busy_prev && !BUSY) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_end", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("error", ERROR, e.err);
                  check("freq_value", FREQ_VALUE, e.value);
                  check("valid_pulses", vcnt, e.nvalid);
                  check("aw_count", aw_log.size(), e.nwr);
                  check("w_count", w_log.size(), e.nwr);
                  check("ar_count", ar_log.size(), e.rd ? 1 : 0);
                  foreach (aw_log[i]) check("awaddr", aw_log[i], BASE);
                  foreach (w_log[i])  check("wdata", w_log[i], (i == 0) ? 32'h8000_0000 : 32'h0);
                  foreach (ar_log[i]) check("araddr", ar_log[i], BASE + 32'd4);
               end
               aw_log.delete(); w_log.delete(); ar_log.delete();
               vcnt = 0;
            end
            busy_prev = BUSY;
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   // Reference: two writes, one read; success updates the value, error keeps it.
   task automatic expect_read(input logic [31:0] d, input logic [1:0] r);
      exp_t e;
      rd_t  x;
      x.d = d; x.r = r;
      rd_q.push_back(x);
      e.err    = (r != 2'b00);
      e.nvalid = e.err ? 0 : 1;
      if (!e.err) model_val = d;
      e.value  = model_val;
      e.nwr    = 2;
      e.rd     = 1'b1;
      exp_pulses += e.nvalid;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) tick();
   endtask

   task automatic check_idle_bus(input string name);
      check({name, "_awvalid"}, bus.M_AXI_AWVALID, 0);
      check({name, "_wvalid"},  bus.M_AXI_WVALID, 0);
      check({name, "_bready"},  bus.M_AXI_BREADY, 0);
      check({name, "_arvalid"}, bus.M_AXI_ARVALID, 0);
      check({name, "_rready"},  bus.M_AXI_RREADY, 0);
   endtask

   task automatic check_reset_state(input string name);
      check_idle_bus(name);
      check({name, "_busy"},   BUSY, 0);
      check({name, "_valid"},  FREQ_VALID, 0);
      check({name, "_error"},  ERROR, 0);
      check({name, "_value"},  FREQ_VALUE, 0);
      check({name, "_awaddr"}, bus.M_AXI_AWADDR, 0);
      check({name, "_wdata"},  bus.M_AXI_WDATA, 0);
      check({name, "_araddr"}, bus.M_AXI_ARADDR, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k;
      exp_t e;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      check_reset_state("reset");
      check("awcache", bus.M_AXI_AWCACHE, 4'b0011);
      check("arcache", bus.M_AXI_ARCACHE, 4'b0011);
      check("awprot", bus.M_AXI_AWPROT, 3'b000);
      check("arprot", bus.M_AXI_ARPROT, 3'b000);
      check("wstrb", bus.M_AXI_WSTRB, 4'hF);
      tick();

`ifdef AQ_FREQ_POLLER_AUTO_EN
      expect_read(32'd5, 2'b00);
      expect_read(32'd6, 2'b00);
      expect_read(32'd7, 2'b00);
      expect_read(32'd0, 2'b10);
      pulse_start();
      wait_done("auto_done", 400);
      repeat (5) tick();
      check("auto_stopped_busy", BUSY, 0);
      check("auto_stopped_error", ERROR, 1);
`else
      // Zero-wait slave: exact START-to-FREQ_VALID latency and single-cycle pulse.
      expect_read(32'd1234, 2'b00);
      pulse_start();
      n = 0;
      while (!FREQ_VALID && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      check("latency", n, WAITC + 32'd7);
      check("lat_value", FREQ_VALUE, 32'd1234);
      @(negedge ACLK);
      check("valid_one_cycle", FREQ_VALID, 0);
      check("busy_after", BUSY, 0);
      wait_done("zero_wait_done", 100);

      // W accepted several cycles before AW: AWVALID must hold.
      aw_stall = 1'b1;
      expect_read(32'hA5A5_0001, 2'b00);
      pulse_start();
      n = 0;
      while (bus.M_AXI_WVALID && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      repeat (3) @(negedge ACLK);
      check("stall_awvalid", bus.M_AXI_AWVALID, 1);
      check("stall_wvalid", bus.M_AXI_WVALID, 0);
      tick();
      aw_stall = 1'b0;
      wait_done("stall_done", 200);

      // Random readies, random data, occasional error response, ignored extra START.
      rnd_mode = 1'b1;
      for (int t = 0; t < 12; t++) begin
         expect_read($urandom, ($urandom_range(5) == 0) ? 2'b10 : 2'b00);
         pulse_start();
         if ($urandom_range(1) == 1) begin
            repeat (2) tick();
            pulse_start();
         end
         wait_done("rand_done", 500);
      end
      rnd_mode = 1'b0;

      // Success first so the error read has a known value to preserve.
      expect_read(32'h0000_4321, 2'b00);
      pulse_start();
      wait_done("pre_err_done", 100);
      expect_read(32'hDEAD_BEEF, 2'b10);
      pulse_start();
      wait_done("rresp_err_done", 100);

      // Reset in the middle of WAIT, then a full measurement.
      pulse_start();
      repeat (10) tick();
      check("in_wait_busy", BUSY, 1);
      check("in_wait_arvalid", bus.M_AXI_ARVALID, 0);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      model_val = 32'h0;
      @(negedge ACLK);
      check_reset_state("midreset");
      tick();
      expect_read(32'd777, 2'b00);
      pulse_start();
      wait_done("post_reset_done", 100);

      // Slave never answers the write: timeout back to IDLE with ERROR.
      b_never = 1'b1;
      e.value = model_val; e.err = 1'b1; e.nvalid = 0; e.nwr = 1; e.rd = 1'b0;
      exp_q.push_back(e);
      pulse_start();
      n = 0;
      while (!bus.M_AXI_BREADY && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      k = 0;
      while (BUSY && k < 100) begin
         @(negedge ACLK);
         k++;
      end
      check("timeout_cycles", k, 16);
      check("timeout_error", ERROR, 1);
      check_idle_bus("timeout");
      wait_done("timeout_done", 50);
`endif

      check("total_pulses", seen_pulses, exp_pulses);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
